// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : phase_sequencer
// Description : Steps the matrix datapath through capture, send, compute and
//               display phases with per-phase timeout and display rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int DWELL   = 8,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       abort,
    input  logic [2:0] mode,
    input  logic       done_capture,
    input  logic       done_send,
    input  logic       done_PE,
    input  logic       done_SA_3x3,
    input  logic       done_SA_2x2,
    output logic       state_idle,
    output logic       state_capture,
    output logic       state_send,
    output logic       state_PE,
    output logic       state_SA_3x3,
    output logic       state_SA_2x2,
    output logic       state_display,
    output logic [1:0] display_sel,
    output logic [2:0] cur_state,
    output logic       busy,
    output logic       error,
    output logic [2:0] err_phase,
    output logic       done_all
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_SEND    = 3'd2,
        S_PE      = 3'd3,
        S_SA3     = 3'd4,
        S_SA2     = 3'd5,
        S_DISPLAY = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [CW-1:0] C_TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_DW_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_mode;
    logic          r_run_q;

    state_t        w_state_nxt;
    state_t        w_phase_after;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_mode_nxt;
    logic [1:0]    w_sel_nxt;
    logic [2:0]    w_sel_rem;
    logic [2:0]    w_errph_nxt;
    logic          w_err_nxt;
    logic          w_done_all_nxt;
    logic          w_done_cur;
    logic          w_start;

    // m holds only the compute phases still ahead of the current one
    function automatic state_t f_next_phase(input logic [2:0] m);
        if (m[0])      return S_PE;
        else if (m[1]) return S_SA3;
        else if (m[2]) return S_SA2;
        else           return S_DISPLAY;
    endfunction

    function automatic logic [1:0] f_first_set(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd0;
    endfunction

    always_comb begin
        w_start        = run & ~r_run_q;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_mode_nxt     = r_mode;
        w_sel_nxt      = display_sel;
        w_err_nxt      = error;
        w_errph_nxt    = err_phase;
        w_done_all_nxt = 1'b0;
        w_done_cur     = 1'b0;
        w_phase_after  = S_DISPLAY;

        case (r_state)
            S_CAPTURE: begin w_done_cur = done_capture; w_phase_after = S_SEND;                          end
            S_SEND:    begin w_done_cur = done_send;    w_phase_after = f_next_phase(r_mode);            end
            S_PE:      begin w_done_cur = done_PE;      w_phase_after = f_next_phase(r_mode & 3'b110);   end
            S_SA3:     begin w_done_cur = done_SA_3x3;  w_phase_after = f_next_phase(r_mode & 3'b100);   end
            S_SA2:     begin w_done_cur = done_SA_2x2;  w_phase_after = S_DISPLAY;                       end
            default:   begin w_done_cur = 1'b0;         w_phase_after = S_DISPLAY;                       end
        endcase

        case (display_sel)
            2'd0:    w_sel_rem = r_mode & 3'b110;
            2'd1:    w_sel_rem = r_mode & 3'b100;
            default: w_sel_rem = 3'b000;
        endcase

        case (r_state)
            S_IDLE, S_ERROR: begin
                // abort only blocks a start from IDLE; ERROR ignores it
                if (w_start && !(abort && (r_state == S_IDLE))) begin
                    w_state_nxt = S_CAPTURE;
                    w_cnt_nxt   = '0;
                    w_mode_nxt  = mode;
                    w_err_nxt   = 1'b0;
                    w_errph_nxt = 3'd0;
                end
            end
            S_DISPLAY: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_DW_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_sel_rem != 3'b000) begin
                        w_sel_nxt = f_first_set(w_sel_rem);
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_done_all_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_done_cur) begin
                    w_state_nxt = w_phase_after;
                    w_cnt_nxt   = '0;
                    if (w_phase_after == S_DISPLAY) w_sel_nxt = f_first_set(r_mode);
                end else if (r_cnt == C_TO_LAST) begin
                    w_state_nxt = S_ERROR;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_errph_nxt = r_state;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_mode        <= 3'd0;
            r_run_q       <= 1'b0;
            display_sel   <= 2'd0;
            error         <= 1'b0;
            err_phase     <= 3'd0;
            done_all      <= 1'b0;
            busy          <= 1'b0;
            state_idle    <= 1'b1;
            state_capture <= 1'b0;
            state_send    <= 1'b0;
            state_PE      <= 1'b0;
            state_SA_3x3  <= 1'b0;
            state_SA_2x2  <= 1'b0;
            state_display <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_mode        <= w_mode_nxt;
            r_run_q       <= run;
            display_sel   <= w_sel_nxt;
            error         <= w_err_nxt;
            err_phase     <= w_errph_nxt;
            done_all      <= w_done_all_nxt;
            busy          <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERROR);
            state_idle    <= (w_state_nxt == S_IDLE);
            state_capture <= (w_state_nxt == S_CAPTURE);
            state_send    <= (w_state_nxt == S_SEND);
            state_PE      <= (w_state_nxt == S_PE);
            state_SA_3x3  <= (w_state_nxt == S_SA3);
            state_SA_2x2  <= (w_state_nxt == S_SA2);
            state_display <= (w_state_nxt == S_DISPLAY);
        end
    end

    assign cur_state = r_state;

endmodule
`default_nettype wire

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Sequences the matrix-compute datapath through capture, send, single-PE, 3x3 systolic array, 2x2 systolic array and display phases.
- Adds per-phase timeout supervision, a latched phase-enable mask and a timed display rotation.
- Sits between the user run/abort controls and the memory, computation and display blocks.
- Drives their one-hot phase enables and consumes their done pulses.

Parameters:
- TIMEOUT, 64: max cycles spent in any compute/transfer phase before error (>=2).
- DWELL, 8: cycles each result set is shown in DISPLAY (>=1).
- CW, 8: width of the shared phase/dwell cycle counter; must hold max(TIMEOUT, DWELL).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- run  in  1  start request, level; rising edge detected internally.
- abort  in  1  synchronous abort, level.
- mode  in  3  phase enable mask: bit0=PE, bit1=SA_3x3, bit2=SA_2x2.
- done_capture, done_send, done_PE, done_SA_3x3, done_SA_2x2  in  1 each  phase completion from the datapath.
- state_idle, state_capture, state_send, state_PE, state_SA_3x3, state_SA_2x2, state_display  out  1 each  registered one-hot phase enables.
- display_sel  out  2  result set shown: 0=PE, 1=3x3, 2=2x2.
- cur_state  out  3  state code.
- busy  out  1  high in any state other than IDLE or ERROR.
- error  out  1  sticky timeout flag.
- err_phase  out  3  state code that timed out.
- done_all  out  1  one-cycle pulse on DISPLAY->IDLE.

Behaviour:
- State codes: IDLE=0, CAPTURE=1, SEND=2, PE=3, SA3=4, SA2=5, DISPLAY=6, ERROR=7.
- All outputs are registered and change only on the rising edge of clk.
- Reset (reset=0, async): state=IDLE, state_idle=1, every other state_* =0, display_sel=0, busy=0, error=0, err_phase=0, done_all=0, counter=0, mode latch=0, run edge register=0.
- Run edge: run_q is registered every cycle; start = run & ~run_q.
- IDLE: on start, latch mode into mode_r, go to CAPTURE, clear error and err_phase. If run is held high, nothing restarts.
- Done inputs are honoured only in their own state; a stray done in any other state is ignored.
- A done sampled high at edge N moves the state at edge N, so the new one-hot output is visible in cycle N+1.
- CAPTURE -> SEND on done_capture.
- SEND -> first enabled phase among PE, SA3, SA2 (in that order) on done_send; goes to DISPLAY if mode_r==0.
- PE, SA3 and SA2 each advance on their own done to the next enabled phase in order, else to DISPLAY.
- Timeout counter:
  - cleared on every state entry and increments each cycle in CAPTURE through SA2.
  - when it equals TIMEOUT-1 with no done that cycle: go to ERROR, set error=1, err_phase=current state code.
  - done and timeout in the same cycle: done wins.
- ERROR: all phase enables low, busy=0. Leaves to CAPTURE on start (which clears error); abort has no effect.
- DISPLAY:
  - display_sel starts at the lowest enabled set, or 0 if mode_r==0.
  - counter runs 0..DWELL-1 per set, then advances to the next enabled set.
  - after the last enabled set: go to IDLE with done_all=1 for one cycle.
  - mode_r==0: one DWELL period showing set 0.
- display_sel holds its last value in IDLE and is reset to 0 only by reset.
- Abort:
  - abort=1 in any busy state: next edge goes to IDLE; counter cleared; error unchanged; done_all stays 0.
  - abort has priority over done and timeout.
  - abort and start in the same IDLE cycle: abort wins, stay IDLE.
- mode changes after start have no effect until the next start.
- Reset mid-phase returns immediately to IDLE with outputs at their reset values.
- The counter never wraps, because state exits at TIMEOUT-1 or DWELL-1.

Test Plan (TIMEOUT=16, DWELL=4):
- Reset, mode=3'b111; pulse run; return done_* two cycles after each phase entry -> sequence 1,2,3,4,5,6. Then display_sel 0,1,2 for 4 cycles each, done_all pulse, state_idle=1.
- mode=3'b010, full run -> PE and SA2 never entered; SEND->SA3->DISPLAY; display_sel=1 for 4 cycles only.
- done_send withheld after start -> ERROR 16 cycles after SEND entry, error=1, err_phase=2, busy=0. A new run edge -> CAPTURE with error=0.
- done_PE asserted exactly on cycle 15 of PE -> advances to SA3, no error. A stray done_SA_2x2 during CAPTURE -> ignored.
- abort asserted in SA3 -> IDLE next cycle, done_all=0. Run held high throughout -> no restart until run drops and rises again.
- reset pulled low mid-DISPLAY, asynchronous to clk -> all outputs at reset values before the next clk edge.
